// File: rtl/mmio_pkg.sv
// Shared definitions for memory-mapped peripherals: register offsets within
// an 8-word block and the base-address alignment check.
package mmio_pkg;

    localparam int OFF_W = 3;

    localparam logic [OFF_W-1:0] OFF_IN      = 3'd0;
    localparam logic [OFF_W-1:0] OFF_OUT     = 3'd1;
    localparam logic [OFF_W-1:0] OFF_OUT_SET = 3'd2;
    localparam logic [OFF_W-1:0] OFF_OUT_CLR = 3'd3;
    localparam logic [OFF_W-1:0] OFF_OUT_TGL = 3'd4;
    localparam logic [OFF_W-1:0] OFF_EDGE    = 3'd5;
    localparam logic [OFF_W-1:0] OFF_EDGE_EN = 3'd6;

    // A block base must sit on an 8-word boundary so the low offset bits are free.
    function automatic bit base_aligned(input longint unsigned base);
        return (base % 64'd8) == 64'd0;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: two-flop synchroniser, stability-count debouncer and a
// single-cycle pulse on the edge where the debounced value rises.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic deb,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic deb_reg;
    logic load;

    // Bring the asynchronous input into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: follow the synchronised input every cycle.
            assign load = (sync2_reg != deb_reg);
        end else begin : g_count
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_reg;

            assign load = (sync2_reg != deb_reg) && (cnt_reg == CNT_LAST);

            // Count consecutive mismatch cycles; any agreement restarts the count.
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if ((sync2_reg != deb_reg) && !load) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end else begin
                    cnt_reg <= '0;
                end
            end
        end
    endgenerate

    // Commit the new level once the input has been stable long enough.
    always_ff @(posedge clock) begin
        if (reset) begin
            deb_reg <= 1'b0;
        end else if (load) begin
            deb_reg <= sync2_reg;
        end
    end

    // A load always flips deb, so a load of 1 is exactly a 0->1 transition.
    assign rise = load & sync2_reg;
    assign deb  = deb_reg;

endmodule

// File: rtl/mmio_gpio_ctrl.sv
// Memory-mapped GPIO block: debounced inputs with sticky rising-edge flags and
// interrupt, plus an output register with atomic set/clear/toggle writes.
module mmio_gpio_ctrl
    import mmio_pkg::*;
#(
    parameter int                N_IN            = 4,
    parameter int                N_OUT           = 4,
    parameter int                DATA_W          = 32,
    parameter int                ADDR_W          = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = 16'hFFF8,
    parameter int                DEBOUNCE_CYCLES = 4,
    parameter logic [N_OUT-1:0]  OUT_RESET       = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    output logic [DATA_W-1:0] data_out,
    output logic              sel,
    input  logic [N_IN-1:0]   io_in,
    output logic [N_OUT-1:0]  io_out,
    output logic              irq
);

    // A misaligned base would alias offsets, so such a block never decodes.
    localparam bit BASE_OK = base_aligned(longint'(BASE_ADDR));

    logic [N_IN-1:0]   deb_vec;
    logic [N_IN-1:0]   rise_vec;
    logic [N_OUT-1:0]  out_reg, out_next;
    logic [N_IN-1:0]   edge_flags_reg, edge_flags_next;
    logic [N_IN-1:0]   edge_en_reg, edge_en_next;
    logic [DATA_W-1:0] data_out_reg, rd_data_next;
    logic              sel_reg;
    logic              hit;
    logic              wr;
    logic [OFF_W-1:0]  offset;
    logic [N_IN-1:0]   w1c_mask;
    logic              unused_data;

    // Only the low channel bits of write data are meaningful.
    assign unused_data = ^data_in;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_in
            gpio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clock (clock),
                .reset (reset),
                .raw   (io_in[gi]),
                .deb   (deb_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    assign hit    = BASE_OK && (address[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W]);
    assign wr     = hit & we;
    assign offset = address[OFF_W-1:0];

    // Next-state of the writable registers; a new rise beats a same-cycle W1C.
    always_comb begin
        out_next     = out_reg;
        edge_en_next = edge_en_reg;
        w1c_mask     = '0;
        if (wr) begin
            case (offset)
                OFF_OUT:     out_next     = data_in[N_OUT-1:0];
                OFF_OUT_SET: out_next     = out_reg | data_in[N_OUT-1:0];
                OFF_OUT_CLR: out_next     = out_reg & ~data_in[N_OUT-1:0];
                OFF_OUT_TGL: out_next     = out_reg ^ data_in[N_OUT-1:0];
                OFF_EDGE:    w1c_mask     = data_in[N_IN-1:0];
                OFF_EDGE_EN: edge_en_next = data_in[N_IN-1:0];
                default:     ;
            endcase
        end
        edge_flags_next = (edge_flags_reg & ~w1c_mask) | rise_vec;
    end

    // Read mux over the pre-write register values; write-only and reserved read 0.
    always_comb begin
        rd_data_next = '0;
        if (hit) begin
            case (offset)
                OFF_IN:      rd_data_next[N_IN-1:0]  = deb_vec;
                OFF_OUT:     rd_data_next[N_OUT-1:0] = out_reg;
                OFF_EDGE:    rd_data_next[N_IN-1:0]  = edge_flags_reg;
                OFF_EDGE_EN: rd_data_next[N_IN-1:0]  = edge_en_reg;
                default:     ;
            endcase
        end
    end

    // Register file and registered bus response.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_reg        <= OUT_RESET;
            edge_flags_reg <= '0;
            edge_en_reg    <= '0;
            data_out_reg   <= '0;
            sel_reg        <= 1'b0;
        end else begin
            out_reg        <= out_next;
            edge_flags_reg <= edge_flags_next;
            edge_en_reg    <= edge_en_next;
            data_out_reg   <= rd_data_next;
            sel_reg        <= hit;
        end
    end

    assign data_out = data_out_reg;
    assign sel      = sel_reg;
    assign io_out   = out_reg;
    assign irq      = |(edge_flags_reg & edge_en_reg);

endmodule
